// File: rtl/skeleton_pixel_streamer_if.sv
// Bus bundle for the skeleton pixel streamer: shared BRAM read port plus the
// valid/ready pixel stream toward the scorer.
interface skeleton_pixel_streamer_if #(
  parameter int unsigned AW          = 16,
  parameter int unsigned SCORE_MEM_W = 8,
  parameter int unsigned SW          = 4
);
  logic [AW-1:0]          addr_out;
  logic                   rd_en_out;
  logic                   skel_rd_data;
  logic [SCORE_MEM_W-1:0] score_rd_data;
  logic                   valid_out;
  logic                   ready_in;
  logic                   skeleton_bit;
  logic [SW-1:0]          pixel_score;
  logic                   is_last_pixel;

  modport master (
    output addr_out, rd_en_out, valid_out, skeleton_bit, pixel_score, is_last_pixel,
    input  skel_rd_data, score_rd_data, ready_in
  );

  modport slave (
    input  addr_out, rd_en_out, valid_out, skeleton_bit, pixel_score, is_last_pixel,
    output skel_rd_data, score_rd_data, ready_in
  );
endinterface

// File: rtl/skeleton_pixel_streamer.sv
// Raster-scans the skeleton and score BRAMs and streams one beat per pixel.
// Optional feature macro: SCORE_CLAMP_EN (saturate scores at MAX_PIXEL_SCORE).
module skeleton_pixel_streamer #(
  parameter int unsigned HRES            = 320,
  parameter int unsigned VRES            = 180,
  parameter int unsigned MAX_PIXEL_SCORE = 7,
  parameter int unsigned SCORE_MEM_W     = 8,
  parameter int unsigned BRAM_LATENCY    = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       start_in,
  skeleton_pixel_streamer_if.master  bus,
  output logic                       busy_out,
  output logic                       done_out
);
  localparam int unsigned NPIX  = HRES * VRES;
  localparam int unsigned AW    = $clog2(NPIX);
  localparam int unsigned XW    = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int unsigned YW    = (VRES > 1) ? $clog2(VRES) : 1;
  localparam int unsigned PW    = $clog2(MAX_PIXEL_SCORE);
  localparam int unsigned SW    = PW + 1;
  localparam int unsigned LAT   = BRAM_LATENCY;
  localparam int unsigned DEPTH = BRAM_LATENCY + 2;
  localparam int unsigned PTRW  = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

  state_e                     state_q, state_d;
  logic [XW-1:0]              x_q, x_d;
  logic [YW-1:0]              y_q, y_d;
  logic                       rd_en_q, rd_en_d;
  logic                       rd_last_q, rd_last_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [LAT-1:0]             tag_vld_q, tag_vld_d;
  logic [LAT-1:0]             tag_last_q, tag_last_d;
  logic [DEPTH-1:0]           mem_skel_q, mem_skel_d;
  logic [DEPTH-1:0][SW-1:0]   mem_score_q, mem_score_d;
  logic [DEPTH-1:0]           mem_last_q, mem_last_d;
  logic [PTRW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       valid_q, valid_d;
  logic                       skel_q, skel_d;
  logic [SW-1:0]              score_q, score_d;
  logic                       last_q, last_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       last_addr_c;
  logic                       pop_c;
  logic                       push_c;
  logic                       issue_c;
  logic [CW-1:0]              occ_c;
  logic [SW-1:0]              score_push_c;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Score narrowing applied as a beat enters the FIFO
`ifdef SCORE_CLAMP_EN
  always_comb begin
    score_push_c = SW'(MAX_PIXEL_SCORE);
    if (bus.score_rd_data <= SCORE_MEM_W'(MAX_PIXEL_SCORE)) score_push_c = SW'(bus.score_rd_data);
  end
`else
  always_comb begin
    score_push_c = bus.score_rd_data[PW:0];
  end
`endif

  // Occupancy counts FIFO entries plus every read still travelling through the BRAM.
  // A pop in the same cycle frees a slot, which keeps 1 beat/cycle with ready held high.
  always_comb begin
    last_addr_c = (x_q == XW'(HRES - 1)) && (y_q == YW'(VRES - 1));
    pop_c       = valid_q & bus.ready_in;
    push_c      = tag_vld_q[LAT-1];
    occ_c       = count_q + CW'(rd_en_q);
    for (int i = 0; i < int'(LAT); i++) occ_c = occ_c + CW'(tag_vld_q[i]);
    issue_c     = (state_q == SCAN) && ((occ_c < CW'(DEPTH)) || pop_c);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    rd_en_d     = issue_c;
    rd_last_d   = issue_c & last_addr_c;
    tag_vld_d   = tag_vld_q;
    tag_last_d  = tag_last_q;
    mem_skel_d  = mem_skel_q;
    mem_score_d = mem_score_q;
    mem_last_d  = mem_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    case (state_q)
      IDLE: if (start_in) begin
        state_d = SCAN;
        x_d     = '0;
        y_d     = '0;
      end
      SCAN:    if (issue_c && last_addr_c) state_d = DRAIN;
      DRAIN:   if (pop_c && last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Raster walk: address for this read, then advance x/y
    if (issue_c) begin
      addr_d = AW'(y_q) * AW'(HRES) + AW'(x_q);
      if (x_q == XW'(HRES - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(VRES - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    tag_vld_d[0]  = rd_en_q;
    tag_last_d[0] = rd_last_q;
    for (int i = 1; i < int'(LAT); i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_last_d[i] = tag_last_q[i-1];
    end

    if (push_c) begin
      mem_skel_d[wr_ptr_q]  = bus.skel_rd_data;
      mem_score_d[wr_ptr_q] = score_push_c;
      mem_last_d[wr_ptr_q]  = tag_last_q[LAT-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CW'(push_c) - CW'(pop_c);

    // Output registers mirror the next FIFO head so they hold while stalled
    valid_d = (count_d != '0);
    skel_d  = mem_skel_d[rd_ptr_d];
    score_d = mem_score_d[rd_ptr_d];
    last_d  = mem_last_d[rd_ptr_d];
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_last_q   <= 1'b0;
      tag_vld_q   <= '0;
      tag_last_q  <= '0;
      mem_skel_q  <= '0;
      mem_score_q <= '0;
      mem_last_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      skel_q      <= 1'b0;
      score_q     <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      rd_en_q     <= rd_en_d;
      rd_last_q   <= rd_last_d;
      tag_vld_q   <= tag_vld_d;
      tag_last_q  <= tag_last_d;
      mem_skel_q  <= mem_skel_d;
      mem_score_q <= mem_score_d;
      mem_last_q  <= mem_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      skel_q      <= skel_d;
      score_q     <= score_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.addr_out      = addr_q;
  assign bus.rd_en_out     = rd_en_q;
  assign bus.valid_out     = valid_q;
  assign bus.skeleton_bit  = skel_q;
  assign bus.pixel_score   = score_q;
  assign bus.is_last_pixel = last_q;
  assign busy_out          = busy_q;
  assign done_out          = done_q;
endmodule
